// File: rtl/acc_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// acc_mem_bus_ctrl
//   Bus controller between the accelerator master port (acc_*) and a
//   word-wide synchronous SRAM (mem_*). One request is in flight at a time:
//   it is acknowledged with a one-cycle acc_ready pulse, the SRAM strobes are
//   driven for that same cycle, and read data comes back as a one-cycle
//   acc_rvalid pulse RD_LAT+1 edges after the request was sampled.
//
//   Optional feature macro: ACC_BUS_RANGE_CHK_EN
//     defined   : byte addresses beyond the SRAM are flagged with acc_err,
//                 never reach the SRAM, and reads return 32'hDEAD_BEEF.
//     undefined : upper address bits ignored (word address wraps),
//                 acc_err tied low.
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   acc_valid/addr/wdata/wstrb  request from the master (wstrb==0 -> read)
//   acc_ready                   one-cycle accept pulse
//   acc_rdata/acc_rvalid        read data and its one-cycle valid pulse
//   acc_err                     one-cycle out-of-range pulse (with acc_ready)
//   mem_en/we/addr/wdata        SRAM strobes, byte enables, word address, data
//   mem_rdata                   SRAM read data
// ---------------------------------------------------------------------------
`ifndef FE_ADDR_W
`define FE_ADDR_W 22
`endif
`ifndef FE_DATA_W
`define FE_DATA_W 32
`endif

module acc_mem_bus_ctrl #(
  parameter int ADDR_W = `FE_ADDR_W,
  parameter int DATA_W = `FE_DATA_W,
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 2,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_valid,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  input  logic [STRB_W-1:0] acc_wstrb,
  output logic              acc_ready,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_rvalid,
  output logic              acc_err,
  output logic              mem_en,
  output logic [STRB_W-1:0] mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       req_read;

  // Byte-offset bits never matter; the upper bits only matter when the
  // range check is built in.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[ADDR_W-1:MEM_AW+2]};

`ifdef ACC_BUS_RANGE_CHK_EN
  logic req_err;
  logic addr_oor;
  assign addr_oor = |acc_addr[ADDR_W-1:MEM_AW+2];
`else
  assign acc_err = 1'b0;
`endif

  // Single request FSM. Every output is a register updated here, so the
  // SRAM strobes and acc_ready are asserted for exactly the ACK cycle, and
  // the latency counter times the read return from the SRAM address edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      req_read   <= 1'b0;
      acc_ready  <= 1'b0;
      acc_rdata  <= '0;
      acc_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef ACC_BUS_RANGE_CHK_EN
      req_err    <= 1'b0;
      acc_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (acc_valid) begin
            state     <= ACK;
            acc_ready <= 1'b1;
            req_read  <= (acc_wstrb == '0);
            mem_addr  <= acc_addr[MEM_AW+1:2];
            mem_wdata <= acc_wdata;
`ifdef ACC_BUS_RANGE_CHK_EN
            // Out-of-range requests are still acknowledged but the SRAM is
            // never touched, so writes are silently dropped.
            req_err   <= addr_oor;
            acc_err   <= addr_oor;
            mem_en    <= !addr_oor;
            mem_we    <= addr_oor ? '0 : acc_wstrb;
`else
            mem_en    <= 1'b1;
            mem_we    <= acc_wstrb;
`endif
          end
        end
        ACK: begin
          // acc_valid is deliberately not looked at here: the master may
          // still be holding it for the request just accepted.
          acc_ready <= 1'b0;
          mem_en    <= 1'b0;
          mem_we    <= '0;
`ifdef ACC_BUS_RANGE_CHK_EN
          acc_err   <= 1'b0;
`endif
          if (req_read) begin
            state   <= RD_WAIT;
            lat_cnt <= 3'(RD_LAT - 1);
          end else begin
            state   <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == '0) begin
`ifdef ACC_BUS_RANGE_CHK_EN
            acc_rdata <= req_err ? DATA_W'(32'hDEAD_BEEF) : mem_rdata;
`else
            acc_rdata <= mem_rdata;
`endif
            acc_rvalid <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          acc_rvalid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_acc_mem_bus_ctrl
//   Self-checking bench for acc_mem_bus_ctrl. Contains a behavioural SRAM
//   with configurable read latency and a word-array reference model of the
//   memory contents and of the expected request/response timing.
//   Optional macro: ACC_BUS_RANGE_CHK_EN (same meaning as in the RTL).
//   Parameter RD_LAT sets the read latency used for the DUT and the SRAM.
// ---------------------------------------------------------------------------
module tb_acc_mem_bus_ctrl #(
  parameter int RD_LAT = 2
);

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int MEM_AW = 10;

  logic              clk;
  logic              rst;
  logic              acc_valid;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [STRB_W-1:0] acc_wstrb;
  logic              acc_ready;
  logic [DATA_W-1:0] acc_rdata;
  logic              acc_rvalid;
  logic              acc_err;
  logic              mem_en;
  logic [STRB_W-1:0] mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int test_cnt = 0;
  int fail_cnt = 0;

  acc_mem_bus_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MEM_AW(MEM_AW),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .acc_valid (acc_valid),
    .acc_addr  (acc_addr),
    .acc_wdata (acc_wdata),
    .acc_wstrb (acc_wstrb),
    .acc_ready (acc_ready),
    .acc_rdata (acc_rdata),
    .acc_rvalid(acc_rvalid),
    .acc_err   (acc_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous SRAM: address sampled on an enabled edge,
  // read data emerges RD_LAT edges later through a shift pipeline.
  logic [DATA_W-1:0] sram [1024];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_en) begin
      rd_pipe[0] <= sram[mem_addr];
      for (int b = 0; b < STRB_W; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Reference model: plain word array indexed by byte address / 4.
  logic [DATA_W-1:0] ref_mem [1024];

  function automatic bit ref_oor(input logic [ADDR_W-1:0] a);
`ifdef ACC_BUS_RANGE_CHK_EN
    return a >= 22'd4096;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_idx(input logic [ADDR_W-1:0] a);
    return int'(a / 4) % 1024;
  endfunction

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    if (ref_oor(a)) return 32'hDEAD_BEEF;
    return ref_mem[ref_idx(a)];
  endfunction

  task automatic ref_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [STRB_W-1:0] s);
    int idx;
    if (ref_oor(a)) return;
    idx = ref_idx(a);
    for (int b = 0; b < STRB_W; b++)
      if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction: request, accept checks, and for reads the
  // latency, data and single-cycle pulse checks.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [STRB_W-1:0] s);
    bit                oor;
    int                edges;
    logic [DATA_W-1:0] exp_rd;
    oor = ref_oor(a);
    @(negedge clk);
    acc_valid = 1'b1;
    acc_addr  = a;
    acc_wdata = d;
    acc_wstrb = s;
    @(posedge clk); #1;
    checkOutput("ready_pulse", 32'(acc_ready), 32'd1);
    checkOutput("err_pulse", 32'(acc_err), 32'(oor));
    checkOutput("mem_en", 32'(mem_en), 32'(!oor));
    checkOutput("mem_we", 32'(mem_we), oor ? 32'd0 : 32'(s));
    if (!oor) checkOutput("mem_addr", 32'(mem_addr), 32'(ref_idx(a)));
    if (s != 0 && !oor) checkOutput("mem_wdata", mem_wdata, d);
    // Scramble the bus after acceptance: the latched request must complete.
    acc_valid = 1'b0;
    acc_addr  = ADDR_W'($urandom);
    acc_wdata = $urandom;
    acc_wstrb = STRB_W'($urandom);
    @(posedge clk); #1;
    checkOutput("ready_drop", 32'(acc_ready), 32'd0);
    checkOutput("en_drop", 32'(mem_en), 32'd0);
    if (s == 0) begin
      exp_rd = ref_read(a);
      edges  = 1;
      while (!acc_rvalid && edges < 20) begin
        @(posedge clk); #1;
        edges++;
      end
      checkOutput("rd_latency", 32'(edges), 32'(RD_LAT + 1));
      checkOutput("rd_data", acc_rdata, exp_rd);
      @(posedge clk); #1;
      checkOutput("rvalid_pulse", 32'(acc_rvalid), 32'd0);
      checkOutput("rdata_hold", acc_rdata, exp_rd);
    end else begin
      ref_write(a, d, s);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int                 issued;
    int                 got;
    int                 cyc;
    int                 bad;
    int                 rv_cnt;
    bit                 busy;
    logic [DATA_W-1:0]  exp_q[$];
    logic [ADDR_W-1:0]  ra;
    logic [STRB_W-1:0]  rs;

    rst       = 1'b1;
    acc_valid = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    acc_wstrb = '0;
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_zero",
                32'(|{acc_ready, acc_rvalid, acc_err, mem_en, mem_we, mem_addr, mem_wdata, acc_rdata}),
                32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic read of word 5
    sram[5] = 32'd5; ref_mem[5] = 32'd5;
    applyStimulus(22'h14, 32'd0, 4'h0);

    // Full write, partial byte-lane write, read back
    applyStimulus(22'h100, 32'h1C, 4'hF);
    applyStimulus(22'h100, 32'hAABB, 4'b0010);
    checkOutput("byte_lane", sram[64], 32'h0000_AA1C);
    applyStimulus(22'h100, 32'd0, 4'h0);

    // Beyond-SRAM address: wraps to word 0, or flagged with range check
    sram[0] = 32'h11; ref_mem[0] = 32'h11;
    applyStimulus(22'h1000, 32'd0, 4'h0);

    // Back-to-back reads with acc_valid held high throughout
    for (int i = 0; i < 8; i++) begin
      sram[i]    = i;
      ref_mem[i] = i;
    end
    issued = 0; got = 0; cyc = 0; busy = 1'b0;
    @(negedge clk);
    acc_valid = 1'b1;
    acc_addr  = '0;
    acc_wstrb = '0;
    while (got < 8 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (acc_rvalid) begin
        if (exp_q.size() == 0) checkOutput("b2b_spurious_rvalid", 32'(acc_rvalid), 32'd0);
        else checkOutput("b2b_data", acc_rdata, exp_q.pop_front());
        got++;
        busy = 1'b0;
      end
      if (acc_ready) begin
        checkOutput("b2b_single_outstanding", 32'(busy), 32'd0);
        exp_q.push_back(ref_read(acc_addr));
        busy = 1'b1;
        issued++;
        if (issued < 8) acc_addr = ADDR_W'(issued * 4);
        else acc_valid = 1'b0;
      end
    end
    acc_valid = 1'b0;
    checkOutput("b2b_ready_count", 32'(issued), 32'd8);
    checkOutput("b2b_rvalid_count", 32'(got), 32'd8);

    // Reset asserted while a read is waiting on the SRAM
    @(negedge clk);
    acc_valid = 1'b1;
    acc_addr  = 22'h20;
    acc_wstrb = '0;
    @(posedge clk); #1;
    acc_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("midread_reset_zero",
                32'(|{acc_ready, acc_rvalid, acc_err, mem_en, mem_we, mem_addr, mem_wdata, acc_rdata}),
                32'd0);
    @(negedge clk);
    rst = 1'b0;
    rv_cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (acc_rvalid) rv_cnt++;
    end
    checkOutput("no_rvalid_after_reset", 32'(rv_cnt), 32'd0);

    // Randomized mix of reads and writes, some beyond the SRAM range
    for (int i = 0; i < 40; i++) begin
      ra = (i % 4 == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 4095));
      rs = ($urandom_range(0, 1) == 0) ? 4'h0 : STRB_W'($urandom_range(1, 15));
      applyStimulus(ra, $urandom, rs);
    end

    // Whole memory image must equal the model
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (sram[i] !== ref_mem[i]) bad++;
    checkOutput("mem_image", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
